bus_master_arbiter: RTL and testbench
=====================================

BUS_MASTER_ARBITER -- requirements
Module: bus_master_arbiter

Interface
REQ-001 Parameter: none; widths fixed at address 30 bits (word address), data 32 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 arb_mode  in  1  arbitration policy: 0 = round-robin, 1 = fixed priority (m0 highest, m3 lowest).
REQ-006 mN_req_  in  1  (N = 0..3) bus request from master N, active-low.
REQ-007 mN_addr  in  30  master N word address.
REQ-008 mN_as_  in  1  master N address strobe, active-low.
REQ-009 mN_rw  in  1  master N read/write, 1 = read, 0 = write.
REQ-010 mN_wr_data  in  32  master N write data.
REQ-011 mN_grnt_  out  1  (N = 0..3) bus grant to master N, active-low.
REQ-012 s_addr  out  30  address forwarded to the shared bus.
REQ-013 s_as_  out  1  address strobe forwarded to the shared bus, active-low.
REQ-014 s_rw  out  1  read/write forwarded to the shared bus.
REQ-015 s_wr_data  out  32  write data forwarded to the shared bus.
REQ-016 owner  out  2  index of the current bus owner, for status and debug.

Function
REQ-017 A 2-bit owner register SHALL hold the current owner; exactly one mN_grnt_ SHALL be low at all times, decoded combinationally from owner (grant parking).
REQ-018 s_addr, s_as_, s_rw and s_wr_data SHALL be combinational copies of the owner's mN_addr, mN_as_, mN_rw and mN_wr_data; non-owner inputs SHALL have no effect on s_*.
REQ-019 Hold rule: while the owner's mN_req_ = 0, owner SHALL NOT change, regardless of other requests or arb_mode.
REQ-020 Release rule: in a cycle where the owner's mN_req_ = 1, the next owner SHALL be chosen from the other masters with mN_req_ = 0.
REQ-021 Round-robin (arb_mode = 0): the search order SHALL be owner+1, owner+2, owner+3 (mod 4), and the first requester found wins.
REQ-022 Fixed priority (arb_mode = 1): the lowest-index requester SHALL win.
REQ-023 If no master requests, owner SHALL remain unchanged (park on the last owner).
REQ-024 The new owner SHALL take effect on the next rising edge; the new grant SHALL be visible 1 cycle after the previous owner deasserts its request, with no idle cycle in which zero grants are asserted.
REQ-025 A request from a parked owner SHALL proceed with zero arbitration latency, because its grant is already asserted.
REQ-026 Wrap-around: in round-robin mode with owner = 3, the search order SHALL be 0, 1, 2.
REQ-027 arb_mode is sampled only at a release decision; a change while the owner holds the bus SHALL NOT alter the owner.
REQ-028 Simultaneous events: when the owner releases and several masters request in the same cycle, the result SHALL follow REQ-021/REQ-022 exactly; the releasing master's own request in that cycle is by definition 1, so it is never re-selected.
REQ-029 The arbiter SHALL NOT observe bus ready or data; each master keeps mN_req_ low until its access completes.

Reset
REQ-030 On reset = 1 at a rising edge, owner SHALL become 0, so m0_grnt_ = 0 and m1_grnt_..m3_grnt_ = 1.
REQ-031 While reset is asserted, s_* SHALL equal m0's inputs.
REQ-032 Reset asserted mid-tenure SHALL force owner = 0 on that edge, with no other retained state.
REQ-033 The first arbitration after reset release SHALL follow REQ-019 to REQ-023 from owner = 0.

Verification
REQ-034 Reset -> owner = 0, m0_grnt_ = 0, other grants 1; drive m0_addr = 30'h1234 -> s_addr = 30'h1234.
REQ-035 Round-robin: owner = 0 and m0 idle; m1, m2 and m3 request together -> owner = 1; when m1 releases -> owner = 2; when m2 releases -> owner = 3; when m3 releases with m0 and m1 requesting -> owner = 0.
REQ-036 Fixed priority: arb_mode = 1, owner = 2 releases while m3 and m1 request -> owner = 1 on the next cycle.
REQ-037 Hold: owner = 1 keeps m1_req_ = 0 for 10 cycles while m0, m2 and m3 request and arb_mode toggles -> owner = 1 throughout, and s_wr_data tracks m1_wr_data.
REQ-038 Park: owner = 2 releases and no master requests -> owner stays 2; m2 then requests -> m2_grnt_ stays 0 with no gap.
REQ-039 Reset mid-tenure: owner = 3 holding its request and reset pulsed for 1 cycle -> owner = 0, m0_grnt_ = 0, m3_grnt_ = 1 on the next cycle.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// Four-master shared-bus arbiter with grant parking, selectable round-robin or
// fixed-priority release policy, and a combinational owner-steered bus mux.
module bus_master_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        arb_mode,
  input  logic        m0_req_,
  input  logic [29:0] m0_addr,
  input  logic        m0_as_,
  input  logic        m0_rw,
  input  logic [31:0] m0_wr_data,
  input  logic        m1_req_,
  input  logic [29:0] m1_addr,
  input  logic        m1_as_,
  input  logic        m1_rw,
  input  logic [31:0] m1_wr_data,
  input  logic        m2_req_,
  input  logic [29:0] m2_addr,
  input  logic        m2_as_,
  input  logic        m2_rw,
  input  logic [31:0] m2_wr_data,
  input  logic        m3_req_,
  input  logic [29:0] m3_addr,
  input  logic        m3_as_,
  input  logic        m3_rw,
  input  logic [31:0] m3_wr_data,
  output logic        m0_grnt_,
  output logic        m1_grnt_,
  output logic        m2_grnt_,
  output logic        m3_grnt_,
  output logic [29:0] s_addr,
  output logic        s_as_,
  output logic        s_rw,
  output logic [31:0] s_wr_data,
  output logic [1:0]  owner
);

  logic [1:0] owner_r;
  logic [1:0] next_owner_s;
  logic [1:0] sel_s;
  logic [3:0] req_s;

  // Lowest-index requester wins; with no requester the current owner parks.
  function automatic logic [1:0] fixed_pick(input logic [3:0] req, input logic [1:0] cur);
    logic [1:0] pick;
    casez (req)
      4'b???1: pick = 2'd0;
      4'b??10: pick = 2'd1;
      4'b?100: pick = 2'd2;
      4'b1000: pick = 2'd3;
      default: pick = cur;
    endcase
    return pick;
  endfunction

  // Search cur+1, cur+2, cur+3 (mod 4); the first requester wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] cur);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;
    logic [1:0] pick;
    c1 = cur + 2'd1;
    c2 = cur + 2'd2;
    c3 = cur + 2'd3;
    casez ({req[c3], req[c2], req[c1]})
      3'b??1:  pick = c1;
      3'b?10:  pick = c2;
      3'b100:  pick = c3;
      default: pick = cur;
    endcase
    return pick;
  endfunction

  assign req_s = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // Next-owner decision: hold while the owner requests, otherwise arbitrate.
  always_comb begin
    next_owner_s = owner_r;
    if (req_s[owner_r]) begin
      next_owner_s = owner_r;
    end else if (arb_mode) begin
      next_owner_s = fixed_pick(req_s, owner_r);
    end else begin
      next_owner_s = rr_pick(req_s, owner_r);
    end
  end

  // Owner register; reset parks the bus on master 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r <= 2'd0;
    end else begin
      owner_r <= next_owner_s;
    end
  end

  assign owner    = owner_r;
  assign m0_grnt_ = (owner_r != 2'd0);
  assign m1_grnt_ = (owner_r != 2'd1);
  assign m2_grnt_ = (owner_r != 2'd2);
  assign m3_grnt_ = (owner_r != 2'd3);

  // Master 0 drives the bus while reset is held, even before the first edge.
  assign sel_s = reset ? 2'd0 : owner_r;

  // Bus mux: forward only the selected master's access signals.
  always_comb begin
    s_addr    = m0_addr;
    s_as_     = m0_as_;
    s_rw      = m0_rw;
    s_wr_data = m0_wr_data;
    case (sel_s)
      2'd0: begin
        s_addr = m0_addr; s_as_ = m0_as_; s_rw = m0_rw; s_wr_data = m0_wr_data;
      end
      2'd1: begin
        s_addr = m1_addr; s_as_ = m1_as_; s_rw = m1_rw; s_wr_data = m1_wr_data;
      end
      2'd2: begin
        s_addr = m2_addr; s_as_ = m2_as_; s_rw = m2_rw; s_wr_data = m2_wr_data;
      end
      2'd3: begin
        s_addr = m3_addr; s_as_ = m3_as_; s_rw = m3_rw; s_wr_data = m3_wr_data;
      end
      default: begin
        s_addr = m0_addr; s_as_ = m0_as_; s_rw = m0_rw; s_wr_data = m0_wr_data;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Table-driven bench for bus_master_arbiter plus hand sequences for the
// address passthrough after reset and the ten-cycle hold with mode toggling.
module tb_bus_master_arbiter;

  logic        clk;
  logic        reset;
  logic        arb_mode;
  logic [3:0]  req_n_v;
  logic [29:0] addr_v [4];
  logic [3:0]  as_n_v;
  logic [3:0]  rw_v;
  logic [31:0] wdata_v [4];
  logic        m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [29:0] s_addr;
  logic        s_as_;
  logic        s_rw;
  logic [31:0] s_wr_data;
  logic [1:0]  owner;

  int n_checks;
  int n_pass;

  bus_master_arbiter dut (
    .clk(clk), .reset(reset), .arb_mode(arb_mode),
    .m0_req_(req_n_v[0]), .m0_addr(addr_v[0]), .m0_as_(as_n_v[0]), .m0_rw(rw_v[0]), .m0_wr_data(wdata_v[0]),
    .m1_req_(req_n_v[1]), .m1_addr(addr_v[1]), .m1_as_(as_n_v[1]), .m1_rw(rw_v[1]), .m1_wr_data(wdata_v[1]),
    .m2_req_(req_n_v[2]), .m2_addr(addr_v[2]), .m2_as_(as_n_v[2]), .m2_rw(rw_v[2]), .m2_wr_data(wdata_v[2]),
    .m3_req_(req_n_v[3]), .m3_addr(addr_v[3]), .m3_as_(as_n_v[3]), .m3_rw(rw_v[3]), .m3_wr_data(wdata_v[3]),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       mode;
    logic [3:0] req_n;   // {m3,m2,m1,m0}, active-low
    logic [1:0] exp_owner;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_owner(input string tag, input logic [1:0] exp);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b1111;
    exp_gnt[exp] = 1'b0;
    check({tag, " owner"}, {30'd0, owner}, {30'd0, exp});
    check({tag, " grants"}, {28'd0, m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}, {28'd0, exp_gnt});
    check({tag, " s_addr"}, {2'b00, s_addr}, {2'b00, addr_v[exp]});
    check({tag, " s_ctl"}, {30'd0, s_as_, s_rw}, {30'd0, as_n_v[exp], rw_v[exp]});
    check({tag, " s_wr_data"}, s_wr_data, wdata_v[exp]);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    arb_mode = 1'b0;
    req_n_v  = 4'b1111;
    as_n_v   = 4'b1010;
    rw_v     = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      addr_v[i]  = 30'h0100_0000 + 30'(i * 30'h11);
      wdata_v[i] = 32'hC0DE_0000 + 32'(i * 32'h101);
    end

    //           rst   mode  req_n    owner
    tbl[0]  = '{1'b1, 1'b0, 4'b1111, 2'd0};  // reset
    tbl[1]  = '{1'b0, 1'b0, 4'b0001, 2'd1};  // m0 idle, m1..m3 request
    tbl[2]  = '{1'b0, 1'b0, 4'b0001, 2'd1};  // m1 holds
    tbl[3]  = '{1'b0, 1'b0, 4'b0011, 2'd2};  // m1 releases
    tbl[4]  = '{1'b0, 1'b0, 4'b0111, 2'd3};  // m2 releases
    tbl[5]  = '{1'b0, 1'b0, 4'b1100, 2'd0};  // m3 releases, m0/m1 request
    tbl[6]  = '{1'b0, 1'b1, 4'b0000, 2'd0};  // hold under mode change
    tbl[7]  = '{1'b0, 1'b0, 4'b0001, 2'd1};  // rr from 0
    tbl[8]  = '{1'b0, 1'b1, 4'b0011, 2'd2};  // fixed: m2 beats m3
    tbl[9]  = '{1'b0, 1'b1, 4'b0101, 2'd1};  // fixed: owner 2 releases, m1 beats m3
    tbl[10] = '{1'b0, 1'b0, 4'b1011, 2'd2};  // only m2 requests
    tbl[11] = '{1'b0, 1'b0, 4'b1111, 2'd2};  // park on 2
    tbl[12] = '{1'b0, 1'b0, 4'b1011, 2'd2};  // parked m2 requests, no gap
    tbl[13] = '{1'b0, 1'b0, 4'b0111, 2'd3};  // m2 releases, m3 requests
    tbl[14] = '{1'b0, 1'b0, 4'b1001, 2'd1};  // wrap: owner 3 -> m1 first of 0,1,2
    tbl[15] = '{1'b0, 1'b0, 4'b0111, 2'd3};  // rr from 1 reaches 3
    tbl[16] = '{1'b1, 1'b0, 4'b0111, 2'd0};  // reset mid-tenure
    tbl[17] = '{1'b0, 1'b0, 4'b0111, 2'd3};  // first arbitration from owner 0
    tbl[18] = '{1'b0, 1'b1, 4'b1101, 2'd1};  // m3 releases, m1 requests

    #1;
    for (int r = 0; r < 19; r++) begin
      reset    = tbl[r].rst;
      arb_mode = tbl[r].mode;
      req_n_v  = tbl[r].req_n;
      #1;
      if (tbl[r].rst) begin
        check($sformatf("row%0d reset s_addr", r), {2'b00, s_addr}, {2'b00, addr_v[0]});
      end else begin
        check($sformatf("row%0d one-hot grant", r),
              {31'd0, $onehot(~{m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_})}, 32'd1);
      end
      @(posedge clk);
      #1;
      check_owner($sformatf("row%0d", r), tbl[r].exp_owner);
      if (r == 0) begin
        addr_v[0] = 30'h1234;
        #1;
        check("reset m0 addr passthrough", {2'b00, s_addr}, 32'h0000_1234);
      end
    end

    // Owner 1 holds for ten cycles while everyone else requests and mode toggles.
    req_n_v = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      arb_mode   = c[0];
      wdata_v[1] = 32'hA5A5_0000 + 32'(c);
      wdata_v[0] = 32'h5A5A_FF00 + 32'(c);
      @(posedge clk);
      #1;
      check($sformatf("hold%0d owner", c), {30'd0, owner}, 32'd1);
      check($sformatf("hold%0d s_wr_data", c), s_wr_data, 32'hA5A5_0000 + 32'(c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
